dsp_mem_seq: RTL and testbench



---
 rtl/dsp_mem_seq_pkg.sv | 13 +
 rtl/dsp_mem_seq_if.sv | 25 ++
 rtl/dsp_mem_seq_next_bank.sv | 22 ++
 rtl/dsp_mem_seq.sv | 130 +++++++++++++
 tb/tb_dsp_mem_seq.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/dsp_mem_seq_pkg.sv
// dsp_mem_seq_pkg: state encoding, counter width and parameter defaults
// shared by the capture-memory sequencer files.
package dsp_mem_seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_SYNC, S_FILL, S_READ, S_DONE, S_ABORT
  } mem_seq_state_e;
  localparam int MemSeqTimeoutW      = 16;
  localparam int MemSeqNumBanks      = 16;
  localparam int MemSeqTimeoutCycles = 65535;
  function automatic logic [MemSeqTimeoutW-1:0] len_or_one(input logic [MemSeqTimeoutW-1:0] v);
    return (v == '0) ? MemSeqTimeoutW'(1) : v;
  endfunction
endpackage

// File: rtl/dsp_mem_seq_if.sv
// dsp_mem_seq_if: control/status bundle between the sequencer (master)
// and the scan-config / datapath side (slave).
interface dsp_mem_seq_if import dsp_mem_seq_pkg::*; #(
  parameter int NUM_BANKS = MemSeqNumBanks,
  parameter int BANK_W    = $clog2(NUM_BANKS)
);
  logic                 i_start, i_abort, i_fs_locked, i_rd_ack;
  logic [NUM_BANKS-1:0] i_cfg_bank_mask;
  logic [7:0]           i_cfg_rst_cycles;
  logic [15:0]          i_cfg_fill_cycles;
  logic                 o_rst_retime, o_rrst_fs, o_en_retime, o_en_fs;
  logic [NUM_BANKS-1:0] o_wrst_bank, o_rrst_bank, o_en_bank;
  logic                 o_rd_req, o_busy, o_done, o_err_timeout, o_err_empty;
  logic [BANK_W-1:0]    o_rd_bank;
  modport master (
    input  i_start, i_abort, i_fs_locked, i_rd_ack, i_cfg_bank_mask, i_cfg_rst_cycles, i_cfg_fill_cycles,
    output o_rst_retime, o_rrst_fs, o_en_retime, o_en_fs, o_wrst_bank, o_rrst_bank, o_en_bank,
           o_rd_req, o_rd_bank, o_busy, o_done, o_err_timeout, o_err_empty
  );
  modport slave (
    output i_start, i_abort, i_fs_locked, i_rd_ack, i_cfg_bank_mask, i_cfg_rst_cycles, i_cfg_fill_cycles,
    input  o_rst_retime, o_rrst_fs, o_en_retime, o_en_fs, o_wrst_bank, o_rrst_bank, o_en_bank,
           o_rd_req, o_rd_bank, o_busy, o_done, o_err_timeout, o_err_empty
  );
endinterface

// File: rtl/dsp_mem_seq_next_bank.sv
// dsp_mem_seq_next_bank: lowest set mask bit strictly above cur_i,
// or the lowest set bit overall when first_i is high.
module dsp_mem_seq_next_bank import dsp_mem_seq_pkg::*; #(
  parameter int NUM_BANKS = MemSeqNumBanks,
  parameter int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic [NUM_BANKS-1:0] mask_i,
  input  logic [BANK_W-1:0]    cur_i,
  input  logic                 first_i,
  output logic [BANK_W-1:0]    idx_o,
  output logic                 found_o
);
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = NUM_BANKS - 1; i >= 0; i--)
      if (mask_i[i] && (first_i || i > int'(cur_i))) begin
        idx_o   = BANK_W'(i);
        found_o = 1'b1;
      end
  end
endmodule

// File: rtl/dsp_mem_seq.sv
// dsp_mem_seq: start-triggered reset -> frame-sync -> bank fill -> bank
// readout sequencer for the ADC capture memory; all outputs registered.
module dsp_mem_seq import dsp_mem_seq_pkg::*; #(
  parameter int NUM_BANKS      = MemSeqNumBanks,
  parameter int BANK_W         = $clog2(NUM_BANKS),
  parameter int TIMEOUT_CYCLES = MemSeqTimeoutCycles
) (
  input logic           i_clk,
  input logic           i_rst_n,
  dsp_mem_seq_if.master bus
);
  typedef logic [MemSeqTimeoutW-1:0] cnt_t;
  localparam cnt_t TmoLast = cnt_t'(TIMEOUT_CYCLES - 1);
  mem_seq_state_e       state_q, state_d;
  logic [BANK_W-1:0]    bank_q, bank_d, rd_bank_q, nx_idx, lo_idx;
  logic [NUM_BANKS-1:0] mask_q, wrst_q, rrst_q, en_bank_q, bank_oh, lo_mask;
  logic [7:0]           rst_cyc_q;
  cnt_t                 fill_cyc_q, cnt_q, rst_last, fill_last;
  logic                 nx_found, lo_found, tmo_hit, tmo_d, start_ok, hold_rst, run;
  logic                 rst_retime_q, rrst_fs_q, en_retime_q, en_fs_q, rd_req_q, busy_q, done_q;
  logic                 err_tmo_q, err_empty_q;
  // In IDLE the lowest-bank search looks at the live mask so it doubles as the empty check.
  assign lo_mask   = (state_q == S_IDLE) ? bus.i_cfg_bank_mask : mask_q;
  assign start_ok  = (state_q == S_IDLE) && bus.i_start;
  assign rst_last  = len_or_one(cnt_t'(rst_cyc_q)) - cnt_t'(1);
  assign fill_last = len_or_one(fill_cyc_q) - cnt_t'(1);
  assign tmo_hit   = (cnt_q == TmoLast);
  assign bank_oh   = NUM_BANKS'(1) << bank_d;
  assign hold_rst  = state_d inside {S_RESET, S_ABORT};
  assign run       = state_d inside {S_SYNC, S_FILL, S_READ};
  dsp_mem_seq_next_bank #(.NUM_BANKS(NUM_BANKS), .BANK_W(BANK_W)) u_next (
    .mask_i(mask_q), .cur_i(bank_q), .first_i(1'b0), .idx_o(nx_idx), .found_o(nx_found)
  );
  dsp_mem_seq_next_bank #(.NUM_BANKS(NUM_BANKS), .BANK_W(BANK_W)) u_low (
    .mask_i(lo_mask), .cur_i('0), .first_i(1'b1), .idx_o(lo_idx), .found_o(lo_found)
  );
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      S_IDLE:  state_d = !bus.i_start ? S_IDLE : lo_found ? S_RESET : S_DONE;
      S_RESET: state_d = (cnt_q == rst_last) ? S_SYNC : S_RESET;
      S_SYNC:
        if (bus.i_fs_locked) begin
          state_d = S_FILL;
          bank_d  = lo_idx;
        end else if (tmo_hit) begin
          state_d = S_ABORT;
          tmo_d   = 1'b1;
        end
      S_FILL:
        if (cnt_q == fill_last) begin
          state_d = nx_found ? S_FILL : S_READ;
          bank_d  = nx_found ? nx_idx : lo_idx;
        end
      S_READ:
        if (rd_req_q && bus.i_rd_ack) begin
          state_d = nx_found ? S_READ : S_DONE;
          bank_d  = nx_found ? nx_idx : bank_q;
        end else if (tmo_hit) begin
          state_d = S_ABORT;
          tmo_d   = 1'b1;
        end
      default: state_d = S_IDLE;
    endcase
    // Abort outranks a same-cycle timeout, so no error flag in that case.
    if (bus.i_abort && state_q != S_IDLE && state_q != S_ABORT) begin
      state_d = S_ABORT;
      tmo_d   = 1'b0;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      bank_q       <= '0;
      cnt_q        <= '0;
      mask_q       <= '0;
      rst_cyc_q    <= '0;
      fill_cyc_q   <= '0;
      rst_retime_q <= 1'b1;
      rrst_fs_q    <= 1'b1;
      wrst_q       <= '1;
      rrst_q       <= '1;
      en_retime_q  <= 1'b0;
      en_fs_q      <= 1'b0;
      en_bank_q    <= '0;
      rd_req_q     <= 1'b0;
      rd_bank_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_tmo_q    <= 1'b0;
      err_empty_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      cnt_q   <= (state_d != state_q || bank_d != bank_q) ? '0 : (&cnt_q ? cnt_q : cnt_q + cnt_t'(1));
      if (start_ok) begin
        mask_q      <= bus.i_cfg_bank_mask;
        rst_cyc_q   <= bus.i_cfg_rst_cycles;
        fill_cyc_q  <= bus.i_cfg_fill_cycles;
        err_empty_q <= !lo_found;
      end
      err_tmo_q    <= start_ok ? 1'b0 : (err_tmo_q | tmo_d);
      rst_retime_q <= hold_rst ? 1'b1 : run ? 1'b0 : rst_retime_q;
      rrst_fs_q    <= hold_rst ? 1'b1 : run ? 1'b0 : rrst_fs_q;
      en_retime_q  <= run;
      en_fs_q      <= run;
      wrst_q       <= hold_rst ? '1 : (state_d == S_FILL) ? (wrst_q & ~bank_oh) : wrst_q;
      rrst_q       <= hold_rst ? '1 : (state_d == S_READ) ? (rrst_q & ~bank_oh) : rrst_q;
      en_bank_q    <= (state_d inside {S_FILL, S_READ}) ? bank_oh : '0;
      rd_req_q     <= (state_d == S_READ);
      rd_bank_q    <= (state_d == S_READ) ? bank_d : '0;
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_DONE);
    end
  assign bus.o_rst_retime  = rst_retime_q;
  assign bus.o_rrst_fs     = rrst_fs_q;
  assign bus.o_en_retime   = en_retime_q;
  assign bus.o_en_fs       = en_fs_q;
  assign bus.o_wrst_bank   = wrst_q;
  assign bus.o_rrst_bank   = rrst_q;
  assign bus.o_en_bank     = en_bank_q;
  assign bus.o_rd_req      = rd_req_q;
  assign bus.o_rd_bank     = rd_bank_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_done        = done_q;
  assign bus.o_err_timeout = err_tmo_q;
  assign bus.o_err_empty   = err_empty_q;
endmodule

// File: tb/tb_dsp_mem_seq.sv
// tb_dsp_mem_seq: directed cycle-by-cycle checks of the capture-memory sequencer.
module tb_dsp_mem_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  dsp_mem_seq_if #(.NUM_BANKS(16)) bus ();
  dsp_mem_seq #(.NUM_BANKS(16), .TIMEOUT_CYCLES(16)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic go(input logic [15:0] m, input logic [7:0] rc, input logic [15:0] fc);
    bus.i_cfg_bank_mask   = m;
    bus.i_cfg_rst_cycles  = rc;
    bus.i_cfg_fill_cycles = fc;
    bus.i_start = 1'b1;
    step(1);
    bus.i_start = 1'b0;
  endtask
  initial begin
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_fs_locked = 1'b0;
    bus.i_rd_ack = 1'b1;
    bus.i_cfg_bank_mask = '0;
    bus.i_cfg_rst_cycles = '0;
    bus.i_cfg_fill_cycles = '0;
    step(1);
    chk("rst_wrst", 32'(bus.o_wrst_bank), 32'hFFFF);
    chk("rst_rrst", 32'(bus.o_rrst_bank), 32'hFFFF);
    chk("rst_resets", {bus.o_rst_retime, bus.o_rrst_fs}, 2'b11);
    chk("rst_flags", {bus.o_en_retime, bus.o_en_fs, bus.o_rd_req, bus.o_busy, bus.o_done,
                      bus.o_err_timeout, bus.o_err_empty}, 7'd0);
    chk("rst_en_bank", 32'(bus.o_en_bank), 32'h0);
    chk("rst_rd_bank", 32'(bus.o_rd_bank), 32'h0);
    rst_n = 1'b1;
    step(1);
    // Run 1: mask 0x0005, rst 3, fill 4, lock after two SYNC cycles, immediate ack.
    go(16'h0005, 8'd3, 16'd4);
    chk("t1_c1_busy", 32'(bus.o_busy), 32'd1);
    chk("t1_c1_ctl", {bus.o_rst_retime, bus.o_rrst_fs, bus.o_en_retime, bus.o_en_fs}, 4'b1100);
    step(2);
    chk("t1_c3_reset", {bus.o_rst_retime, bus.o_en_retime}, 2'b10);
    step(1);
    chk("t1_c4_sync", {bus.o_rst_retime, bus.o_rrst_fs, bus.o_en_retime, bus.o_en_fs}, 4'b0011);
    chk("t1_c4_en_bank", 32'(bus.o_en_bank), 32'h0);
    step(2);
    chk("t1_c6_still_sync", 32'(bus.o_en_bank), 32'h0);
    bus.i_fs_locked = 1'b1;
    step(1);
    chk("t1_c7_fill_b0", 32'(bus.o_en_bank), 32'h0001);
    chk("t1_c7_wrst", 32'(bus.o_wrst_bank), 32'hFFFE);
    step(3);
    chk("t1_c10_fill_b0", 32'(bus.o_en_bank), 32'h0001);
    step(1);
    chk("t1_c11_fill_b2", 32'(bus.o_en_bank), 32'h0004);
    chk("t1_c11_wrst", 32'(bus.o_wrst_bank), 32'hFFFA);
    step(3);
    chk("t1_c14_fill_b2", {bus.o_rd_req, bus.o_en_bank}, 17'h0_0004);
    step(1);
    chk("t1_c15_rd_b0", {bus.o_rd_req, bus.o_rd_bank}, 5'h10);
    chk("t1_c15_en", 32'(bus.o_en_bank), 32'h0001);
    chk("t1_c15_rrst", 32'(bus.o_rrst_bank), 32'hFFFE);
    step(1);
    chk("t1_c16_rd_b2", {bus.o_rd_req, bus.o_rd_bank}, 5'h12);
    chk("t1_c16_en", 32'(bus.o_en_bank), 32'h0004);
    step(1);
    chk("t1_c17_done", {bus.o_done, bus.o_busy, bus.o_rd_req, bus.o_en_retime}, 4'b1100);
    chk("t1_c17_en", 32'(bus.o_en_bank), 32'h0);
    chk("t1_c17_wrst", 32'(bus.o_wrst_bank), 32'hFFFA);
    chk("t1_c17_rrst", 32'(bus.o_rrst_bank), 32'hFFFA);
    step(1);
    chk("t1_c18_idle", {bus.o_done, bus.o_busy}, 2'b00);
    chk("t1_c18_wrst", 32'(bus.o_wrst_bank), 32'hFFFA);
    // Run 2: empty mask goes straight to DONE with no reset activity.
    bus.i_fs_locked = 1'b0;
    go(16'h0000, 8'd3, 16'd4);
    chk("t2_done", {bus.o_done, bus.o_busy, bus.o_err_empty}, 3'b111);
    chk("t2_wrst", 32'(bus.o_wrst_bank), 32'hFFFA);
    chk("t2_rst_retime", 32'(bus.o_rst_retime), 32'd0);
    step(1);
    chk("t2_idle", {bus.o_done, bus.o_busy, bus.o_err_empty}, 3'b001);
    // Run 3: no lock, timeout after 16 SYNC cycles; rst 0 behaves as 1.
    go(16'h0003, 8'd0, 16'd1);
    chk("t3_c1", {bus.o_err_empty, bus.o_rst_retime, bus.o_busy}, 3'b011);
    step(1);
    chk("t3_c2_sync", {bus.o_en_fs, bus.o_rst_retime}, 2'b10);
    step(15);
    chk("t3_c17_sync", {bus.o_en_fs, bus.o_err_timeout}, 2'b10);
    step(1);
    chk("t3_c18_abort", {bus.o_err_timeout, bus.o_rst_retime, bus.o_rrst_fs, bus.o_en_fs, bus.o_busy, bus.o_done},
        6'b111010);
    chk("t3_c18_wrst", 32'(bus.o_wrst_bank), 32'hFFFF);
    step(1);
    chk("t3_c19_idle", {bus.o_busy, bus.o_done, bus.o_err_timeout}, 3'b001);
    // Run 4: abort while filling bank 1, then abort held in IDLE.
    bus.i_fs_locked = 1'b1;
    go(16'h0006, 8'd1, 16'd8);
    chk("t4_c1_err_clr", 32'(bus.o_err_timeout), 32'd0);
    step(2);
    chk("t4_c3_fill_b1", 32'(bus.o_en_bank), 32'h0002);
    chk("t4_c3_wrst", 32'(bus.o_wrst_bank), 32'hFFFD);
    bus.i_abort = 1'b1;
    step(1);
    chk("t4_c4_wrst", 32'(bus.o_wrst_bank), 32'hFFFF);
    chk("t4_c4_rrst", 32'(bus.o_rrst_bank), 32'hFFFF);
    chk("t4_c4_en", 32'(bus.o_en_bank), 32'h0);
    chk("t4_c4_ctl", {bus.o_rst_retime, bus.o_en_retime, bus.o_en_fs, bus.o_busy, bus.o_done, bus.o_err_timeout},
        6'b100100);
    step(1);
    chk("t4_c5_idle", {bus.o_busy, bus.o_done}, 2'b00);
    step(1);
    chk("t4_c6_abort_idle", {bus.o_busy, bus.o_wrst_bank}, 17'h0_FFFF);
    bus.i_abort = 1'b0;
    // Run 5: restart request and mask change during READ are ignored.
    bus.i_rd_ack = 1'b0;
    go(16'h0009, 8'd1, 16'd1);
    step(2);
    chk("t5_c3_fill_b0", 32'(bus.o_en_bank), 32'h0001);
    step(1);
    chk("t5_c4_fill_b3", 32'(bus.o_en_bank), 32'h0008);
    chk("t5_c4_wrst", 32'(bus.o_wrst_bank), 32'hFFF6);
    step(1);
    chk("t5_c5_rd_b0", {bus.o_rd_req, bus.o_rd_bank}, 5'h10);
    bus.i_start = 1'b1;
    bus.i_cfg_bank_mask = 16'hFFFF;
    step(1);
    chk("t5_c6_rd_b0", {bus.o_rd_req, bus.o_rd_bank, bus.o_en_bank}, 21'h10_0001);
    bus.i_start = 1'b0;
    bus.i_rd_ack = 1'b1;
    step(1);
    chk("t5_c7_rd_b3", {bus.o_rd_req, bus.o_rd_bank}, 5'h13);
    chk("t5_c7_en", 32'(bus.o_en_bank), 32'h0008);
    chk("t5_c7_rrst", 32'(bus.o_rrst_bank), 32'hFFF6);
    bus.i_rd_ack = 1'b0;
    step(1);
    chk("t5_c8_rd_wait", {bus.o_rd_req, bus.o_rd_bank}, 5'h13);
    bus.i_rd_ack = 1'b1;
    step(1);
    chk("t5_c9_done", {bus.o_done, bus.o_rd_req}, 2'b10);
    chk("t5_c9_rrst", 32'(bus.o_rrst_bank), 32'hFFF6);
    chk("t5_c9_wrst", 32'(bus.o_wrst_bank), 32'hFFF6);
    step(1);
    chk("t5_c10_idle", {bus.o_busy, bus.o_done}, 2'b00);
    // Run 6: asynchronous reset in the middle of READ.
    bus.i_rd_ack = 1'b0;
    go(16'h0001, 8'd1, 16'd1);
    step(3);
    chk("t6_c4_rd", {bus.o_rd_req, bus.o_busy}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_flags", {bus.o_rd_req, bus.o_busy, bus.o_en_retime, bus.o_rst_retime}, 4'b0001);
    chk("t6_async_en", 32'(bus.o_en_bank), 32'h0);
    chk("t6_async_wrst", 32'(bus.o_wrst_bank), 32'hFFFF);
    chk("t6_async_rrst", 32'(bus.o_rrst_bank), 32'hFFFF);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("t6_after_rst", {bus.o_busy, bus.o_done}, 2'b00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
